// File: rtl/vip_mmult_if.sv
// Single-beat AXI4 channel bundle between the matrix-multiply engine and its memory model.
interface vip_mmult_if;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output araddr, arlen, arsize, arburst, arvalid, rready,
    output awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
    input  arready, rdata, rresp, rlast, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arlen, arsize, arburst, arvalid, rready,
    input  awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
    output arready, rdata, rresp, rlast, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/vip_mmult.sv
// Matrix-multiply subsystem: AXI4 master engine computing C = A x B on an internal AXI4 slave memory.
// Optional macro VIP_SLAVE_BACKPRESSURE_EN makes the memory drop its ready signals on alternate cycles.
module vip_mmult_engine #(
  parameter int N = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic        start,
  output logic        done,
  vip_mmult_if.master m
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {IDLE, RD_A, RD_B, MAC, WR, WR_RESP, DONE} state_t;
  state_t state_reg, state_next;

  logic [CW-1:0] i_reg, j_reg, k_reg;
  logic [31:0]   a_reg, b_reg, c_reg, acc_reg, op_a_reg, op_b_reg;
  logic          ar_sent_reg, aw_sent_reg, w_sent_reg;
  logic          rd_state, ar_hs, r_hs, aw_hs, w_hs, b_hs, wr_complete;
  logic          last_k, last_elem;
  logic [31:0]   off_a, off_b, off_c;
  logic          unused_resp;

  assign off_a = (32'(i_reg) * 32'(N) + 32'(k_reg)) << 2;
  assign off_b = (32'(k_reg) * 32'(N) + 32'(j_reg)) << 2;
  assign off_c = (32'(i_reg) * 32'(N) + 32'(j_reg)) << 2;
  assign last_k    = (k_reg == CW'(N - 1));
  assign last_elem = (i_reg == CW'(N - 1)) && (j_reg == CW'(N - 1));

  assign rd_state    = (state_reg == RD_A) || (state_reg == RD_B);
  assign ar_hs       = rd_state && !ar_sent_reg && m.arready;
  assign r_hs        = rd_state && m.rvalid;
  assign aw_hs       = (state_reg == WR) && !aw_sent_reg && m.awready;
  assign w_hs        = (state_reg == WR) && !w_sent_reg && m.wready;
  assign b_hs        = (state_reg == WR_RESP) && m.bvalid;
  assign wr_complete = (aw_sent_reg || aw_hs) && (w_sent_reg || w_hs);

  assign m.araddr  = (state_reg == RD_B) ? (b_reg + off_b) : (a_reg + off_a);
  assign m.arlen   = 8'd0;
  assign m.arsize  = 3'd2;
  assign m.arburst = 2'b01;
  assign m.awaddr  = c_reg + off_c;
  assign m.awlen   = 8'd0;
  assign m.awsize  = 3'd2;
  assign m.awburst = 2'b01;
  assign m.wdata   = acc_reg;
  assign m.wstrb   = 4'hF;
  assign m.wlast   = 1'b1;
  assign unused_resp = ^{m.rresp, m.rlast, m.bresp};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    done       = 1'b0;
    m.arvalid  = 1'b0;
    m.rready   = 1'b0;
    m.awvalid  = 1'b0;
    m.wvalid   = 1'b0;
    m.bready   = 1'b0;
    case (state_reg)
      IDLE:    if (start) state_next = RD_A;
      RD_A: begin
        m.arvalid = !ar_sent_reg;
        m.rready  = 1'b1;
        if (r_hs) state_next = RD_B;
      end
      RD_B: begin
        m.arvalid = !ar_sent_reg;
        m.rready  = 1'b1;
        if (r_hs) state_next = MAC;
      end
      MAC:     state_next = last_k ? WR : RD_A;
      WR: begin
        m.awvalid = !aw_sent_reg;
        m.wvalid  = !w_sent_reg;
        if (wr_complete) state_next = WR_RESP;
      end
      WR_RESP: begin
        m.bready = 1'b1;
        if (b_hs) state_next = last_elem ? DONE : RD_A;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg <= '0; b_reg <= '0; c_reg <= '0;
      i_reg <= '0; j_reg <= '0; k_reg <= '0;
      acc_reg <= '0; op_a_reg <= '0; op_b_reg <= '0;
      ar_sent_reg <= 1'b0; aw_sent_reg <= 1'b0; w_sent_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (start) begin
          a_reg <= a; b_reg <= b; c_reg <= c;
          i_reg <= '0; j_reg <= '0; k_reg <= '0;
          acc_reg <= '0;
          ar_sent_reg <= 1'b0; aw_sent_reg <= 1'b0; w_sent_reg <= 1'b0;
        end
        RD_A, RD_B: begin
          if (ar_hs) ar_sent_reg <= 1'b1;
          if (r_hs) begin
            ar_sent_reg <= 1'b0;
            if (state_reg == RD_A) op_a_reg <= m.rdata;
            else                   op_b_reg <= m.rdata;
          end
        end
        MAC: begin
          acc_reg <= acc_reg + op_a_reg * op_b_reg;
          if (!last_k) k_reg <= k_reg + CW'(1);
        end
        WR: begin
          // AW and W complete independently; flags rearm once both are through
          if (wr_complete) begin
            aw_sent_reg <= 1'b0;
            w_sent_reg  <= 1'b0;
          end else begin
            if (aw_hs) aw_sent_reg <= 1'b1;
            if (w_hs)  w_sent_reg  <= 1'b1;
          end
        end
        WR_RESP: if (b_hs) begin
          acc_reg <= '0;
          k_reg   <= '0;
          if (j_reg == CW'(N - 1)) begin
            j_reg <= '0;
            i_reg <= i_reg + CW'(1);
          end else begin
            j_reg <= j_reg + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

module vip_mmult_mem #(
  parameter int          MEM_WORDS = 4096,
  parameter logic [31:0] FILL      = 32'hFFFF_FFFF
) (
  input logic clk,
  input logic rst,
  vip_mmult_if.slave s
);
  localparam int AW = $clog2(MEM_WORDS);

  // Power-up content; never reset so written words survive rst
  logic [31:0] mem [MEM_WORDS] = '{default: FILL};

  logic          allow;
  logic          arready_reg, rvalid_reg, awready_reg, wready_reg, bvalid_reg;
  logic          aw_got_reg, w_got_reg, aw_ok_reg, w_ok_reg;
  logic [1:0]    rresp_reg, bresp_reg;
  logic [31:0]   rdata_reg, wdata_reg;
  logic [3:0]    wstrb_reg;
  logic [AW-1:0] waddr_reg;
  logic          ar_hs, aw_hs, w_hs, do_write, ar_ok;
  logic          unused_addr;

`ifdef VIP_SLAVE_BACKPRESSURE_EN
  logic toggle_reg;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) toggle_reg <= 1'b0;
    else     toggle_reg <= ~toggle_reg;
  end
  assign allow = toggle_reg;
`else
  assign allow = 1'b1;
`endif

  assign ar_hs    = s.arvalid && arready_reg;
  assign aw_hs    = s.awvalid && awready_reg;
  assign w_hs     = s.wvalid && wready_reg;
  assign do_write = aw_got_reg && w_got_reg && !bvalid_reg;
  assign ar_ok    = (s.arlen == 8'd0) && (s.arsize == 3'd2) && (s.arburst == 2'b01);
  assign unused_addr = ^{s.araddr[31:AW+2], s.araddr[1:0], s.awaddr[31:AW+2], s.awaddr[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arready_reg <= 1'b0; rvalid_reg <= 1'b0; rresp_reg <= 2'b00;
      awready_reg <= 1'b0; wready_reg <= 1'b0; bvalid_reg <= 1'b0; bresp_reg <= 2'b00;
      aw_got_reg <= 1'b0; w_got_reg <= 1'b0; aw_ok_reg <= 1'b0; w_ok_reg <= 1'b0;
      waddr_reg <= '0; wdata_reg <= '0; wstrb_reg <= '0;
    end else begin
      arready_reg <= s.arvalid && !arready_reg && !rvalid_reg && allow;
      if (ar_hs) begin
        rvalid_reg <= 1'b1;
        rresp_reg  <= ar_ok ? 2'b00 : 2'b10;
      end else if (rvalid_reg && s.rready) begin
        rvalid_reg <= 1'b0;
      end

      awready_reg <= s.awvalid && !awready_reg && !aw_got_reg && allow;
      wready_reg  <= s.wvalid && !wready_reg && !w_got_reg && allow;
      if (aw_hs) begin
        aw_got_reg <= 1'b1;
        waddr_reg  <= s.awaddr[AW+1:2];
        aw_ok_reg  <= (s.awlen == 8'd0) && (s.awsize == 3'd2) && (s.awburst == 2'b01);
      end
      if (w_hs) begin
        w_got_reg <= 1'b1;
        wdata_reg <= s.wdata;
        wstrb_reg <= s.wstrb;
        w_ok_reg  <= s.wlast;
      end
      if (do_write) begin
        aw_got_reg <= 1'b0;
        w_got_reg  <= 1'b0;
        bvalid_reg <= 1'b1;
        bresp_reg  <= (aw_ok_reg && w_ok_reg) ? 2'b00 : 2'b10;
      end else if (bvalid_reg && s.bready) begin
        bvalid_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ar_hs) rdata_reg <= mem[s.araddr[AW+1:2]];
    if (do_write) begin
      for (int lane = 0; lane < 4; lane++) begin
        if (wstrb_reg[lane]) mem[waddr_reg][8*lane +: 8] <= wdata_reg[8*lane +: 8];
      end
    end
  end

  assign s.arready = arready_reg;
  assign s.rvalid  = rvalid_reg;
  assign s.rdata   = rdata_reg;
  assign s.rresp   = rresp_reg;
  assign s.rlast   = 1'b1;
  assign s.awready = awready_reg;
  assign s.wready  = wready_reg;
  assign s.bvalid  = bvalid_reg;
  assign s.bresp   = bresp_reg;
endmodule

module vip_mmult #(
  parameter int          N         = 4,
  parameter int          MEM_WORDS = 4096,
  parameter logic [31:0] FILL      = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic        start,
  output logic        done
);
  vip_mmult_if axi ();

  vip_mmult_engine #(.N(N)) u_eng (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .start(start), .done(done), .m(axi.master)
  );

  vip_mmult_mem #(.MEM_WORDS(MEM_WORDS), .FILL(FILL)) u_mem (
    .clk(clk), .rst(rst), .s(axi.slave)
  );
endmodule

// File: tb/tb_vip_mmult.sv
// Scoreboard bench for vip_mmult: expected memory images are queued per run and checked when done pulses.
module tb_vip_mmult;
  localparam int          N    = 4;
  localparam int          MW   = 4096;
  localparam logic [31:0] FILL = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a = '0, b = '0, c = '0;
  logic        done;

  always #5 clk = ~clk;

  vip_mmult #(.N(N), .MEM_WORDS(MW), .FILL(FILL)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .start(start), .done(done)
  );

  int          checks = 0;
  int          errors = 0;
  int          done_count = 0;
  logic        done_prev = 1'b0;
  int          exp_word_q[$];
  logic [31:0] exp_val_q[$];
  string       exp_tag_q[$];
  int          run_len_q[$];
  logic [31:0] ma[N*N], mb[N*N], mc[N*N];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  // Monitor: each done pulse retires exactly one queued run
  always @(negedge clk) begin
    if (done) begin
      done_count++;
      check("done_single_cycle", {31'b0, done_prev}, 32'd0);
      if (run_len_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 required no done (no run pending)");
      end else begin
        int n;
        n = run_len_q.pop_front();
        for (int e = 0; e < n; e++) begin
          int w;
          logic [31:0] v;
          string t;
          w = exp_word_q.pop_front();
          v = exp_val_q.pop_front();
          t = exp_tag_q.pop_front();
          check($sformatf("%s_mem[%0d]", t, w), dut.u_mem.mem[w], v);
        end
      end
    end
    done_prev <= done;
  end

  function automatic int word_of(input logic [31:0] addr);
    return int'((addr >> 2) % MW);
  endfunction

  task automatic push_exp(input int w, input logic [31:0] v, input string tag);
    exp_word_q.push_back(((w % MW) + MW) % MW);
    exp_val_q.push_back(v);
    exp_tag_q.push_back(tag);
  endtask

  task automatic clear_mem();
    for (int w = 0; w < MW; w++) dut.u_mem.mem[w] = FILL;
  endtask

  // Preload A/B, compute C with plain matrix arithmetic, queue the expected image
  task automatic load_run(input logic [31:0] aa, input logic [31:0] bb, input logic [31:0] cc);
    int aw, bw, cw;
    logic [31:0] s;
    aw = word_of(aa);
    bw = word_of(bb);
    cw = word_of(cc);
    for (int e = 0; e < N*N; e++) dut.u_mem.mem[(aw + e) % MW] = ma[e];
    for (int e = 0; e < N*N; e++) dut.u_mem.mem[(bw + e) % MW] = mb[e];
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        s = 32'd0;
        for (int k = 0; k < N; k++) s = s + ma[i*N+k] * mb[k*N+j];
        mc[i*N+j] = s;
      end
    for (int e = 0; e < N*N; e++) push_exp(cw + e, mc[e], "C");
    push_exp(cw - 1, FILL, "iso_below");
    push_exp(cw + N*N, FILL, "iso_above");
    for (int e = 0; e < N*N; e++) push_exp(aw + e, ma[e], "A_kept");
    for (int e = 0; e < N*N; e++) push_exp(bw + e, mb[e], "B_kept");
    run_len_q.push_back(3*N*N + 2);
  endtask

  task automatic pulse_start(input logic [31:0] aa, input logic [31:0] bb, input logic [31:0] cc);
    @(posedge clk);
    #1;
    a = aa; b = bb; c = cc; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int d0;
    int cyc;
    d0 = done_count;
    cyc = 0;
    while (done_count == d0 && cyc < 5000) begin
      @(posedge clk);
      cyc++;
    end
    if (done_count == d0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done in %0d cycles, required done", name, cyc);
      exp_word_q.delete(); exp_val_q.delete(); exp_tag_q.delete(); run_len_q.delete();
    end else begin
      @(negedge clk);
      check({name, "_done_low_after"}, {31'b0, done}, 32'd0);
    end
  endtask

  task automatic run(input string name, input logic [31:0] aa, input logic [31:0] bb, input logic [31:0] cc);
    clear_mem();
    load_run(aa, bb, cc);
    pulse_start(aa, bb, cc);
    wait_done(name);
    $display("run %s: a=%h b=%h c=%h C[0]=%h C[15]=%h", name, aa, bb, cc, mc[0], mc[N*N-1]);
  endtask

  initial begin
    logic [31:0] aa, bb, cc;
    int bcnt, guard, d0;

    // Power-up memory content, before anything is written
    check("mem_init_w0", dut.u_mem.mem[0], FILL);
    check("mem_init_wlast", dut.u_mem.mem[MW-1], FILL);
    repeat (3) @(posedge clk);
    #1;
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_axi_handshakes",
          {22'b0, dut.axi.arvalid, dut.axi.rready, dut.axi.awvalid, dut.axi.wvalid, dut.axi.bready,
           dut.axi.arready, dut.axi.rvalid, dut.axi.awready, dut.axi.wready, dut.axi.bvalid}, 32'd0);
    rst = 1'b0;

    // Identity
    for (int e = 0; e < N*N; e++) begin
      ma[e] = ((e / N) == (e % N)) ? 32'd1 : 32'd0;
      mb[e] = 32'(e + 1);
    end
    run("identity", 32'h0, 32'h100, 32'h200);

    // Constant
    for (int e = 0; e < N*N; e++) begin ma[e] = 32'd2; mb[e] = 32'd3; end
    run("constant", 32'h0, 32'h100, 32'h200);

    // Product overflow plus address wrap and ignored low bits
    for (int e = 0; e < N*N; e++) begin ma[e] = 32'h0001_0000; mb[e] = 32'h0001_0000; end
    run("wrap", 32'h0001_0043, 32'h0000_0302, 32'hFFFF_FC01);

    // Random data in random non-overlapping regions
    for (int r = 0; r < 4; r++) begin
      for (int e = 0; e < N*N; e++) begin
        ma[e] = $urandom;
        mb[e] = (r == 0) ? 32'($urandom_range(0, 255)) : $urandom;
      end
      aa = 32'(($urandom_range(0, 63) * 16) << 2) | 32'($urandom_range(0, 3)) | 32'($urandom_range(0, 3) << 14);
      bb = 32'((1024 + $urandom_range(0, 63) * 16) << 2) | 32'($urandom_range(0, 3));
      cc = 32'((2048 + $urandom_range(1, 62) * 32) << 2) | 32'($urandom_range(0, 3) << 14);
      run($sformatf("random%0d", r), aa, bb, cc);
    end

    // Busy: a second start mid-run must be ignored and must not touch its C region
    for (int e = 0; e < N*N; e++) begin ma[e] = $urandom; mb[e] = $urandom; end
    clear_mem();
    load_run(32'h0, 32'h100, 32'h200);
    for (int e = 0; e < N*N; e++) push_exp(word_of(32'h3000) + e, FILL, "busy_c2");
    run_len_q[run_len_q.size()-1] += N*N;
    pulse_start(32'h0, 32'h100, 32'h200);
    repeat (40) @(posedge clk);
    pulse_start(32'h400, 32'h800, 32'h3000);
    wait_done("busy");
    d0 = done_count;
    repeat (200) @(posedge clk);
    check("busy_no_second_done", 32'(done_count), 32'(d0));
    $display("run busy: second start ignored, done_count=%0d", done_count);

    // Reset during RD_B of element 5
    for (int e = 0; e < N*N; e++) begin ma[e] = $urandom; mb[e] = $urandom; end
    clear_mem();
    load_run(32'h0, 32'h100, 32'h200);
    d0 = done_count;
    pulse_start(32'h0, 32'h100, 32'h200);
    bcnt = 0;
    guard = 0;
    while (bcnt < 5 && guard < 5000) begin
      @(negedge clk);
      guard++;
      if (dut.axi.bvalid && dut.axi.bready) bcnt++;
    end
    while (!(dut.axi.rvalid && dut.axi.rready) && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    check("reset_reach_elem5", {31'b0, guard < 5000}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_done", {31'b0, done}, 32'd0);
    check("midrst_arvalid", {31'b0, dut.axi.arvalid}, 32'd0);
    for (int e = 0; e < 3*N*N + 2; e++) begin
      void'(exp_word_q.pop_back()); void'(exp_val_q.pop_back()); void'(exp_tag_q.pop_back());
    end
    void'(run_len_q.pop_back());
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int e = 0; e < N*N; e++)
      check($sformatf("midrst_C[%0d]", e), dut.u_mem.mem[word_of(32'h200) + e], (e < 5) ? mc[e] : FILL);
    repeat (50) @(posedge clk);
    check("midrst_no_done", 32'(done_count), 32'(d0));
    $display("run reset: aborted after 5 elements, restarting");
    load_run(32'h0, 32'h100, 32'h200);
    pulse_start(32'h0, 32'h100, 32'h200);
    wait_done("after_reset");

    repeat (5) @(posedge clk);
    check("queue_drained", 32'(run_len_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
